// File: rtl/window_pkg.sv
// Shared types and default geometry for the overlapping-window buffer controller.
package window_pkg;

  typedef enum logic {PRIME, RUN} state_e;

  localparam int unsigned ADDRWIDTH_DFLT = 12;
  localparam int unsigned WINLOG_DFLT    = 11;
  localparam int unsigned HOPLOG_DFLT    = 10;

  localparam int unsigned DEPTH_DFLT = 1 << ADDRWIDTH_DFLT;
  localparam int unsigned WIN_DFLT   = 1 << WINLOG_DFLT;
  localparam int unsigned HOP_DFLT   = 1 << HOPLOG_DFLT;

endpackage

// File: rtl/overlap_window_ctrl.sv
// Address/flow controller for a circular sample buffer read as overlapping windows.
// Define OVERLAP_WINDOW_OVERRUN_EN to add sticky overrun/underrun flags.
module overlap_window_ctrl
  import window_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DFLT,
  parameter int unsigned WINLOG    = WINLOG_DFLT,
  parameter int unsigned HOPLOG    = HOPLOG_DFLT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enqueue,
  input  logic                 dequeue,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRWIDTH-1:0] write_addr,
  output logic [ADDRWIDTH-1:0] read_addr,
  output logic [WINLOG-1:0]    window_addr,
  output logic                 window_first,
  output logic                 window_last,
`ifdef OVERLAP_WINDOW_OVERRUN_EN
  output logic                 overrun,
  output logic                 underrun,
`endif
  output logic [ADDRWIDTH:0]   level
);

  localparam int unsigned DEPTH = 1 << ADDRWIDTH;
  localparam int unsigned WIN   = 1 << WINLOG;
  localparam int unsigned HOP   = 1 << HOPLOG;
  localparam int unsigned PW    = ADDRWIDTH + 1;

  localparam logic [ADDRWIDTH:0] DEPTH_L = PW'(DEPTH);
  localparam logic [ADDRWIDTH:0] WIN_L   = PW'(WIN);
  localparam logic [ADDRWIDTH:0] HOP_L   = PW'(HOP);
  localparam logic [WINLOG-1:0]  IDX_END = WINLOG'(WIN - 1);

  if (HOPLOG >= WINLOG || WINLOG > ADDRWIDTH) begin : g_bad_cfg
    $error("overlap_window_ctrl: need HOPLOG < WINLOG <= ADDRWIDTH");
  end

  state_e               state_q, state_d;
  logic [ADDRWIDTH:0]   enq_q, enq_d;
  logic [ADDRWIDTH:0]   base_q, base_d;
  logic [WINLOG-1:0]    idx_q, idx_d;
  logic [ADDRWIDTH:0]   idx_ext;
  logic [ADDRWIDTH:0]   level_d;
  logic                 acc_enq;
  logic                 acc_deq;

  always_comb begin
    idx_ext      = PW'(idx_q);
    level        = enq_q - base_q;
    full         = (level == DEPTH_L);
    empty        = (state_q == PRIME) || (level == idx_ext);
    write_addr   = enq_q[ADDRWIDTH-1:0];
    read_addr    = base_q[ADDRWIDTH-1:0] + idx_ext[ADDRWIDTH-1:0];
    window_addr  = idx_q;
    window_first = (idx_q == '0) && !empty;
    window_last  = (idx_q == IDX_END) && !empty;
  end

  // Flags come from pre-edge state, so a retiring hop never unblocks this cycle's enqueue.
  always_comb begin
    acc_enq = enqueue && !full;
    acc_deq = dequeue && !empty && !flush;
    enq_d   = enq_q + PW'(acc_enq);
    base_d  = base_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (flush) begin
      base_d  = enq_q;
      idx_d   = '0;
    end else if (acc_deq) begin
      if (idx_q == IDX_END) begin
        idx_d  = '0;
        base_d = base_q + HOP_L;
      end else begin
        idx_d  = idx_q + WINLOG'(1);
      end
    end
    level_d = enq_d - base_d;
    if (flush) begin
      state_d = PRIME;
    end else if (state_q == PRIME && level_d >= WIN_L) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PRIME;
      enq_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      enq_q   <= enq_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

`ifdef OVERLAP_WINDOW_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic und_q, und_d;

  always_comb begin
    ovr_d = flush ? 1'b0 : (ovr_q || (enqueue && full));
    und_d = flush ? 1'b0 : (und_q || (dequeue && empty && state_q == RUN));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      und_q <= und_d;
    end
  end

  assign overrun  = ovr_q;
  assign underrun = und_q;
`endif

endmodule

// File: doc/overlap_window_ctrl.md
OVERLAP_WINDOW_CTRL -- requirements
Module: overlap_window_ctrl

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12: buffer depth DEPTH = 2**ADDRWIDTH samples.
REQ-002 SHALL have parameter WINLOG, default 11: window length WIN = 2**WINLOG, with WINLOG <= ADDRWIDTH.
REQ-003 SHALL have parameter HOPLOG, default 10: hop HOP = 2**HOPLOG, with HOPLOG < WINLOG; any other value is an elaboration error.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enqueue  in  1  write one sample at write_addr this cycle.
REQ-007 dequeue  in  1  read one sample at read_addr this cycle.
REQ-008 flush  in  1  discard the window in progress and re-prime.
REQ-009 full  out  1  level == DEPTH; enqueue is ignored.
REQ-010 empty  out  1  no readable sample; dequeue is ignored.
REQ-011 write_addr  out  ADDRWIDTH  RAM write address.
REQ-012 read_addr  out  ADDRWIDTH  RAM read address.
REQ-013 window_addr  out  WINLOG  index within the current window, for the window-function LUT.
REQ-014 window_first  out  1  window_addr == 0 and not empty.
REQ-015 window_last  out  1  window_addr == WIN-1 and not empty.
REQ-016 level  out  ADDRWIDTH+1  samples held from the window base to the write pointer.

Function
REQ-017 Internal pointers enq_ptr and base_ptr SHALL be ADDRWIDTH+1 bits wide and wrap modulo 2**(ADDRWIDTH+1); window index idx SHALL be WINLOG bits wide.
REQ-018 Address mapping SHALL be: write_addr = enq_ptr[ADDRWIDTH-1:0]; read_addr = (base_ptr + idx)[ADDRWIDTH-1:0]; level = enq_ptr - base_ptr.
REQ-019 All outputs SHALL be combinational from registered state only, with no input-to-output paths; the effect of any input SHALL appear after one clock edge.
REQ-020 FSM states SHALL be PRIME and RUN; in PRIME, empty = 1 regardless of level.
REQ-021 PRIME SHALL transition to RUN at the edge where level becomes >= WIN.
REQ-022 In RUN, empty SHALL equal (level == idx).
REQ-023 An accepted enqueue (enqueue && !full) SHALL increment enq_ptr.
REQ-024 An accepted dequeue (dequeue && !empty) with idx < WIN-1 SHALL increment idx.
REQ-025 An accepted dequeue with idx == WIN-1 SHALL set idx to 0 and base_ptr to base_ptr + HOP, and SHALL leave the state in RUN.
REQ-026 When enqueue and dequeue are accepted in the same cycle, both updates SHALL apply; full and empty are evaluated on the pre-edge state, so a hop retiring in the same cycle does not unblock an enqueue.
REQ-027 flush SHALL set base_ptr to enq_ptr (the pre-increment value), idx to 0 and the state to PRIME.
REQ-028 An enqueue in the flush cycle SHALL still be accepted; a dequeue in the flush cycle SHALL be ignored.

Reset
REQ-029 reset SHALL clear enq_ptr, base_ptr and idx to 0 and set the state to PRIME.
REQ-030 Output values after reset SHALL be: empty=1, full=0, level=0, all addresses 0, window_first=0, window_last=0.
REQ-031 reset SHALL take priority over flush, enqueue and dequeue, including mid-window.

Configuration
REQ-032 With OVERLAP_WINDOW_OVERRUN_EN defined, the block SHALL add outputs overrun (sticky; set by enqueue while full) and underrun (sticky; set by dequeue while empty in RUN).
REQ-033 With OVERLAP_WINDOW_OVERRUN_EN defined, overrun and underrun SHALL be cleared only by reset or flush.
REQ-034 Without OVERLAP_WINDOW_OVERRUN_EN, those ports and their registers SHALL NOT exist.

Structure
REQ-035 Package window_pkg SHALL hold the state enum type (PRIME, RUN) and the helper localparams for DEPTH, WIN and HOP.
REQ-036 The block SHALL be a single module with no sub-module; the idx/hop logic is too small to split out.

Verification (ADDRWIDTH=4, WINLOG=3, HOPLOG=2)
REQ-037 Reset: after reset, empty=1, full=0, level=0, read_addr=0 and write_addr=0.
REQ-038 Priming: after 7 enqueues, empty=1 and level=7; after the 8th, empty=0, read_addr=0 and window_first=1.
REQ-039 Window hop: 8 dequeues give window_last=1 on the 8th; next cycle read_addr=4, window_addr=0 and level=4.
REQ-040 Full and wrap: 16 enqueues with no dequeue give full=1 and write_addr=0 (wrapped); a 17th enqueue leaves level=16 and, with the macro defined, sets overrun=1.
REQ-041 Flush: flush at idx=3 with level=10 gives, next cycle, level=0, window_addr=0 and empty=1 (state PRIME).
REQ-042 Simultaneous events: at level=16 and idx=7, assert enqueue and dequeue together; the enqueue is rejected, the next-cycle level is 12, and read_addr is advanced by 4 from the window base.
